// File: rtl/div_fixed_complex_seq_pkg.sv
// -----------------------------------------------------------------------------
// fixed_pkg
// Shared constants, FSM state type and sign/saturation helper for the
// iterative fixed-point complex divider.
//
// Optional feature macro: DIV_FIXED_ROUND_EN
//   undefined : W quotient iterations, magnitude truncated toward zero
//   defined   : W+1 iterations (extra guard bit), round half away from zero
//
// Contents:
//   QI, QF        integer / fractional bits of the Q(QI.QF) format
//   W             operand / result width
//   NW            signed numerator width (a*conj(b) component)
//   DW            dividend width (|N| shifted by the fractional bits)
//   NITER         quotient bits produced per operation
//   RW            working width of the remainder and shifted divisor
//   state_e       IDLE / PREP / DIV / DONE
//   sign_sat()    applies sign and saturation to an unsigned magnitude
// -----------------------------------------------------------------------------
package fixed_pkg;

  localparam int QI = 3;
  localparam int QF = 3;
  localparam int W  = QI + QF;
  localparam int NW = 2*W + 1;
  localparam int DW = 2*W + QF + 1;

`ifdef DIV_FIXED_ROUND_EN
  localparam int NITER = W + 1;
`else
  localparam int NITER = W;
`endif

  // Left shift applied to |N| to form the dividend (one extra bit when a
  // guard bit is produced).
  localparam int DSH  = QF + NITER - W;
  // Room for the dividend and for the divisor shifted up by W.
  localparam int RW   = DW + W + 1;
  localparam int CNTW = $clog2(NITER);

  // Largest magnitudes representable for positive / negative results.
  localparam logic [W:0]   MAG_POS_MAX = (W+1)'(2**(W-1) - 1);
  localparam logic [W:0]   MAG_NEG_MAX = (W+1)'(2**(W-1));
  localparam logic [W-1:0] Y_SAT_POS   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] Y_SAT_NEG   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Returns {saturated, y}. pre_sat forces saturation even when the
  // magnitude itself looks in range (quotient bits are meaningless then).
  function automatic logic [W:0] sign_sat(input logic       neg,
                                          input logic [W:0] mag,
                                          input logic       pre_sat);
    logic [W:0] res;
    if (!neg) begin
      if (pre_sat || (mag > MAG_POS_MAX)) res = {1'b1, Y_SAT_POS};
      else                                res = {1'b0, mag[W-1:0]};
    end else begin
      if (pre_sat || (mag > MAG_NEG_MAX)) res = {1'b1, Y_SAT_NEG};
      else                                res = {1'b0, W'(-mag)};
    end
    return res;
  endfunction

endpackage

// File: rtl/div_fixed_complex_seq_step.sv
// -----------------------------------------------------------------------------
// div_restoring_step
// Combinational one-bit restoring division step: if the partial remainder is
// at least the (already shifted) divisor, subtract it and emit a 1.
//
// Ports:
//   rem_i   partial remainder in
//   div_i   divisor aligned to the current quotient bit
//   rem_o   partial remainder out
//   q_o     quotient bit
// -----------------------------------------------------------------------------
module div_restoring_step #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] rem_i,
  input  logic [SW-1:0] div_i,
  output logic [SW-1:0] rem_o,
  output logic          q_o
);

  always_comb begin
    rem_o = rem_i;
    q_o   = 1'b0;
    if (rem_i >= div_i) begin
      rem_o = rem_i - div_i;
      q_o   = 1'b1;
    end
  end

endmodule

// File: rtl/div_fixed_complex_seq.sv
// -----------------------------------------------------------------------------
// div_fixed_complex_seq
// Iterative fixed-point complex divider y = a / b on signed Q(QI.QF) values.
// Forms a*conj(b) and |b|^2, then runs two restoring divisions (Re, Im) in
// parallel, one quotient bit per cycle.
//
// Optional feature macro: DIV_FIXED_ROUND_EN (guard bit + round half away
// from zero, one extra cycle of latency). Default build truncates.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid / in_ready operand handshake (a_Re, a_Im, b_Re, b_Im)
//   out_valid/out_ready result handshake  (y_Re, y_Im, bad_rep, div_by_zero)
//   bad_rep             at least one component saturated
//   div_by_zero         b was 0+0j (y forced to 0)
//   dbg_state_o         current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE and
// the result is held stable until out_ready is seen, so one operation is in
// flight at a time. out_ready is ignored outside DONE.
//
// Latency: acceptance at edge k -> out_valid high after edge k+NITER+2
// (PREP edge, NITER iteration edges, one sign/saturation edge).
// -----------------------------------------------------------------------------
module div_fixed_complex_seq
  import fixed_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] a_Re,
  input  logic signed [W-1:0] a_Im,
  input  logic signed [W-1:0] b_Re,
  input  logic signed [W-1:0] b_Im,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] y_Re,
  output logic signed [W-1:0] y_Im,
  output logic                bad_rep,
  output logic                div_by_zero,
  output state_e              dbg_state_o
);

  state_e                 state_q;
  logic                   in_ready_q, out_valid_q, bad_q, dz_out_q;
  logic signed [W-1:0]    y_re_q, y_im_q;
  logic signed [W-1:0]    a_re_q, a_im_q, b_re_q, b_im_q;
  logic [RW-1:0]          rem_re_q, rem_im_q;
  logic [NW-1:0]          den_q;
  logic                   sign_re_q, sign_im_q, sat_re_q, sat_im_q, dz_q;
  logic [NITER-1:0]       q_re_q, q_im_q;
  logic [CNTW-1:0]        cnt_q;
  logic                   fin_q;

  // PREP datapath: numerators, denominator, magnitudes, pre-checks.
  logic signed [NW-1:0]   are_x, aim_x, bre_x, bim_x;
  logic signed [NW-1:0]   n_re_c, n_im_c, d_s_c;
  logic [NW-1:0]          nmag_re_c, nmag_im_c, den_c;
  logic [RW-1:0]          dvd_re_c, dvd_im_c, den_w_c;
  logic                   sat_re_c, sat_im_c;

  always_comb begin
    are_x     = NW'(a_re_q);
    aim_x     = NW'(a_im_q);
    bre_x     = NW'(b_re_q);
    bim_x     = NW'(b_im_q);
    n_re_c    = are_x * bre_x + aim_x * bim_x;
    n_im_c    = aim_x * bre_x - are_x * bim_x;
    d_s_c     = bre_x * bre_x + bim_x * bim_x;
    den_c     = $unsigned(d_s_c);
    nmag_re_c = n_re_c[NW-1] ? $unsigned(-n_re_c) : $unsigned(n_re_c);
    nmag_im_c = n_im_c[NW-1] ? $unsigned(-n_im_c) : $unsigned(n_im_c);
    dvd_re_c  = RW'(nmag_re_c) << DSH;
    dvd_im_c  = RW'(nmag_im_c) << DSH;
    den_w_c   = RW'(den_c);
    // Quotient would not fit in W integer+fraction bits.
    sat_re_c  = (RW'(nmag_re_c) << QF) >= (den_w_c << W);
    sat_im_c  = (RW'(nmag_im_c) << QF) >= (den_w_c << W);
  end

  // DIV datapath: divisor aligned to the current quotient bit.
  logic [RW-1:0] dsh_c;
  logic [RW-1:0] rem_re_d, rem_im_d;
  logic          qb_re, qb_im;

  assign dsh_c = RW'(den_q) << cnt_q;

  div_restoring_step #(.SW(RW)) u_step_re (
    .rem_i (rem_re_q),
    .div_i (dsh_c),
    .rem_o (rem_re_d),
    .q_o   (qb_re)
  );

  div_restoring_step #(.SW(RW)) u_step_im (
    .rem_i (rem_im_q),
    .div_i (dsh_c),
    .rem_o (rem_im_d),
    .q_o   (qb_im)
  );

  // Exit from DIV: magnitude, then sign and saturation.
  logic [W:0] mag_re_c, mag_im_c;
  logic [W:0] fin_re_c, fin_im_c;

  always_comb begin
`ifdef DIV_FIXED_ROUND_EN
    mag_re_c = (W+1)'(((W+2)'(q_re_q) + (W+2)'(1)) >> 1);
    mag_im_c = (W+1)'(((W+2)'(q_im_q) + (W+2)'(1)) >> 1);
`else
    mag_re_c = (W+1)'(q_re_q);
    mag_im_c = (W+1)'(q_im_q);
`endif
    fin_re_c = sign_sat(sign_re_q, mag_re_c, sat_re_q);
    fin_im_c = sign_sat(sign_im_q, mag_im_c, sat_im_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      y_re_q      <= '0;
      y_im_q      <= '0;
      bad_q       <= 1'b0;
      dz_out_q    <= 1'b0;
      a_re_q      <= '0;
      a_im_q      <= '0;
      b_re_q      <= '0;
      b_im_q      <= '0;
      rem_re_q    <= '0;
      rem_im_q    <= '0;
      den_q       <= '0;
      sign_re_q   <= 1'b0;
      sign_im_q   <= 1'b0;
      sat_re_q    <= 1'b0;
      sat_im_q    <= 1'b0;
      dz_q        <= 1'b0;
      q_re_q      <= '0;
      q_im_q      <= '0;
      cnt_q       <= '0;
      fin_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_re_q     <= a_Re;
            a_im_q     <= a_Im;
            b_re_q     <= b_Re;
            b_im_q     <= b_Im;
            in_ready_q <= 1'b0;
            state_q    <= PREP;
          end
        end
        PREP: begin
          rem_re_q  <= dvd_re_c;
          rem_im_q  <= dvd_im_c;
          den_q     <= den_c;
          sign_re_q <= n_re_c[NW-1];
          sign_im_q <= n_im_c[NW-1];
          sat_re_q  <= sat_re_c;
          sat_im_q  <= sat_im_c;
          dz_q      <= (den_c == '0);
          q_re_q    <= '0;
          q_im_q    <= '0;
          cnt_q     <= CNTW'(NITER - 1);
          fin_q     <= 1'b0;
          state_q   <= DIV;
        end
        DIV: begin
          if (!fin_q) begin
            rem_re_q <= rem_re_d;
            rem_im_q <= rem_im_d;
            q_re_q   <= {q_re_q[NITER-2:0], qb_re};
            q_im_q   <= {q_im_q[NITER-2:0], qb_im};
            if (cnt_q == '0) fin_q <= 1'b1;
            else             cnt_q <= cnt_q - 1'b1;
          end else begin
            if (dz_q) begin
              y_re_q   <= '0;
              y_im_q   <= '0;
              bad_q    <= 1'b0;
              dz_out_q <= 1'b1;
            end else begin
              y_re_q   <= fin_re_c[W-1:0];
              y_im_q   <= fin_im_c[W-1:0];
              bad_q    <= fin_re_c[W] | fin_im_c[W];
              dz_out_q <= 1'b0;
            end
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign y_Re        = y_re_q;
  assign y_Im        = y_im_q;
  assign bad_rep     = bad_q;
  assign div_by_zero = dz_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/div_fixed_complex_seq.md
Name: div_fixed_complex_seq

Overview:
- Iterative fixed-point complex divider: y = a / b, signed Q(QI.QF) operands and results.
- Inverse of the team's combinational complex multiplier, for equalisation and normalisation stages in the convolution datapath.
- Forms a·conj(b) and |b|², then runs two restoring divisions in parallel, one quotient bit per cycle.
- Valid/ready handshake on both sides.

Parameters:
- QI, 3, integer bits including sign.
- QF, 3, fractional bits; W = QI+QF is the operand width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a_Re, a_Im  in  W  signed dividend.
- b_Re, b_Im  in  W  signed divisor.
- out_valid  out  1  result present; held until accepted.
- out_ready  in  1  consumer accepts the result.
- y_Re, y_Im  out  W  signed quotient.
- bad_rep  out  1  at least one component saturated.
- div_by_zero  out  1  b was 0+0j.

Behaviour:
- Reset (rst_n low at an edge), from any state, including mid-division:
  - state returns to IDLE; in_ready=1; out_valid=0; y_Re=y_Im=0; bad_rep=0; div_by_zero=0.
  - any in-flight operation is discarded.
- FSM states: IDLE, PREP, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register all four operands and go to PREP.
  - Input changes after acceptance are ignored.
- PREP (1 cycle):
  - Numerators: N_re = aRe·bRe + aIm·bIm and N_im = aIm·bRe − aRe·bIm. Each is signed, 2W+1 bits.
  - Denominator: D = bRe² + bIm², unsigned, 2W bits.
  - Latch each numerator's sign and magnitude |N|.
  - Dividend = |N|<<QF; divisor = D.
  - Overflow pre-check per component: sat = (|N|<<QF) ≥ (D<<W).
  - dz = (D==0).
- DIV (exactly W cycles):
  - Restoring division, MSB first, on both components simultaneously.
  - Iteration counter runs W−1 down to 0.
  - Produces unsigned W-bit magnitude quotients.
- Sign and saturation on exit from DIV, per component:
  - result = sign ? −mag : mag.
  - Positive result with mag > 2^(W−1)−1 saturates to 2^(W−1)−1.
  - Negative result with mag > 2^(W−1) saturates to −2^(W−1).
  - The pre-check sat flag forces the same saturation.
  - bad_rep = OR of both components' saturation.
- Divide by zero: dz forces y_Re=y_Im=0, div_by_zero=1, bad_rep=0. Latency is unchanged.
- Rounding: magnitude is truncated, i.e. truncation toward zero.
- Latency: acceptance at edge k gives out_valid high after edge k+W+2.
- DONE:
  - out_valid=1; outputs stable.
  - On out_ready, go to IDLE; out_valid drops at that edge.
  - in_ready stays low until IDLE, so there is no overlap of operations.
- out_ready is ignored outside DONE.

Optional Feature:
- Macro: DIV_FIXED_ROUND_EN.
- Defined:
  - DIV runs W+1 iterations; the extra bit is the guard bit.
  - Magnitude = (mag_ext + 1) >> 1, i.e. round half away from zero, before sign and saturation.
  - Latency becomes W+3.
- Undefined: truncation as above, latency W+2.

Decomposition:
- Shared package fixed_pkg holds:
  - width constants: W, NW = 2W+1, DW = 2W+QF+1.
  - the FSM state enum {IDLE, PREP, DIV, DONE}.
  - saturation-limit constants.
- One sub-module, div_restoring_step: a combinational one-bit restoring step (remainder, divisor in; new remainder, quotient bit out). Instantiated twice (Re, Im).

Test Plan (QI=3, QF=3, LSB 0.125, raw integer values):
- a=(8,0), b=(0,8) [1/(1j)] → y=(0,−8), bad_rep=0, out_valid exactly 8 cycles after accept.
- a=(16,16), b=(8,8) → y=(16,0); a=(8,0), b=(24,0) → y_Re=2 by truncation; y_Re=3 with DIV_FIXED_ROUND_EN.
- a=(24,0), b=(1,0) → y_Re=31, bad_rep=1; a=(−32,0), b=(4,0) → y_Re=−32, bad_rep=1.
- b=(0,0), a=(5,−3) → y=(0,0), div_by_zero=1, bad_rep=0, same latency.
- Hold out_ready low 5 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored; then out_ready=1 → IDLE next edge.
- rst_n low for one edge during DIV cycle 3 → out_valid=0, in_ready=1 next cycle; a fresh operation then completes correctly.
